// File: rtl/gpr_bank_if.sv
// gpr_bank_if: control and status bundle of the general-purpose register bank.
// The shared data bus stays a plain inout on the bank because it is a resolved multi-driver net.
interface gpr_bank_if #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(NREGS);

    logic                   load;
    logic [SEL_W-1:0]       load_sel;
    logic                   drive;
    logic [SEL_W-1:0]       drive_sel;
    logic                   step;
    logic                   step_dir;
    logic                   save;
    logic                   restore;
    logic [NREGS*WIDTH-1:0] regs;
    logic                   wrap;

    modport master (
        output load, load_sel, drive, drive_sel, step, step_dir, save, restore,
        input  regs, wrap
    );

    modport slave (
        input  load, load_sel, drive, drive_sel, step, step_dir, save, restore,
        output regs, wrap
    );
endinterface

// File: rtl/gpr_bank.sv
// gpr_bank: NREGS x WIDTH register bank on a shared tri-state bus, with a stepping index register.
// Define GPR_BANK_SHADOW_EN to add a one-deep shadow copy for interrupt context save/restore.
module gpr_bank #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8,
    parameter int XIDX  = 2
) (
    input  logic            clk,
    input  logic            reset,
    inout  wire [WIDTH-1:0] dbus,
    gpr_bank_if.slave       bus
);
    localparam int SEL_W = $clog2(NREGS);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NREGS*WIDTH-1:0] r_regs;
    logic                   r_wrap;
    logic [NREGS*WIDTH-1:0] w_regs_next;
    logic                   w_wrap_next;
    logic [WIDTH-1:0]       w_drive_val;
    logic [WIDTH-1:0]       w_x;
    logic [WIDTH-1:0]       w_x_next;
    logic                   w_step_en;

    assign bus.regs = r_regs;
    assign bus.wrap = r_wrap;
    assign w_x      = r_regs[XIDX*WIDTH +: WIDTH];

    // A load aimed at the index register takes priority over stepping it.
    assign w_step_en = bus.step & ~(bus.load & (bus.load_sel == SEL_W'(XIDX)));

    // Bus source mux; unmatched selects (beyond NREGS) yield zero.
    always_comb begin
        w_drive_val = {WIDTH{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            w_drive_val = w_drive_val |
                ((bus.drive_sel == SEL_W'(i)) ? r_regs[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
        end
    end

    assign dbus = bus.drive ? w_drive_val : {WIDTH{1'bz}};

`ifdef GPR_BANK_SHADOW_EN
    logic [NREGS*WIDTH-1:0] r_shadow;
    logic                   r_shadow_wrap;
`else
    logic w_unused_shadow_ctrl;
    assign w_unused_shadow_ctrl = bus.save | bus.restore;
`endif

    // Next-state: index step, then bus loads, then (optionally) shadow restore on top.
    always_comb begin
        w_regs_next = r_regs;
        w_x_next    = w_x;
        w_wrap_next = 1'b0;
        if (w_step_en) begin
            if (bus.step_dir == 1'b0) begin
                w_x_next    = w_x + ONE_W;
                w_wrap_next = (w_x == {WIDTH{1'b1}});
            end else begin
                w_x_next    = w_x - ONE_W;
                w_wrap_next = (w_x == {WIDTH{1'b0}});
            end
        end else begin
            w_x_next    = w_x;
            w_wrap_next = 1'b0;
        end
        w_regs_next[XIDX*WIDTH +: WIDTH] = w_x_next;
        // During a drive+load the bus carries the old value, so a self-load is a no-op.
        for (int i = 0; i < NREGS; i++) begin
            w_regs_next[i*WIDTH +: WIDTH] = (bus.load && (bus.load_sel == SEL_W'(i))) ?
                dbus : w_regs_next[i*WIDTH +: WIDTH];
        end
`ifdef GPR_BANK_SHADOW_EN
        w_regs_next = bus.restore ? r_shadow      : w_regs_next;
        w_wrap_next = bus.restore ? r_shadow_wrap : w_wrap_next;
`endif
    end

    // Architectural register and wrap flag update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs <= {(NREGS*WIDTH){1'b0}};
            r_wrap <= 1'b0;
        end else begin
            r_regs <= w_regs_next;
            r_wrap <= w_wrap_next;
        end
    end

`ifdef GPR_BANK_SHADOW_EN
    // Shadow captures pre-update state, which makes save+restore a swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow      <= {(NREGS*WIDTH){1'b0}};
            r_shadow_wrap <= 1'b0;
        end else if (bus.save) begin
            r_shadow      <= r_regs;
            r_shadow_wrap <= r_wrap;
        end else begin
            r_shadow      <= r_shadow;
            r_shadow_wrap <= r_shadow_wrap;
        end
    end
`endif

endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: directed plus random stimulus for gpr_bank, checked by a queue-based scoreboard
// against an array model of the register bank.
module tb_gpr_bank;
    localparam int NREGS = 4;
    localparam int WIDTH = 8;
    localparam int XIDX  = 2;
    localparam int SEL_W = $clog2(NREGS);
    localparam int MOD   = 1 << WIDTH;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    typedef struct {
        logic [NREGS*WIDTH-1:0] regs;
        logic                   wrap;
        logic [WIDTH-1:0]       dbus;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tb_en = 1'b1;
    logic [WIDTH-1:0] tb_val = '0;
    wire  [WIDTH-1:0] dbus;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int mon_cyc = 0;
    int unused_ctrl_cnt = 0;

    int m_regs[NREGS];
    int m_wrap = 0;
    int m_sh[NREGS];
    int m_sh_wrap = 0;

    gpr_bank_if #(.NREGS(NREGS), .WIDTH(WIDTH)) bus ();

    gpr_bank #(.NREGS(NREGS), .WIDTH(WIDTH), .XIDX(XIDX)) dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus),
        .bus   (bus)
    );

    assign dbus = tb_en ? tb_val : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    // One bus cycle: apply inputs at the falling edge and queue what the bank must show after the next rise.
    task automatic cyc(input bit rst, input bit ld, input int lsel, input bit drv, input int dsel,
                       input bit stp, input bit dir, input bit sv, input bit rs,
                       input logic [WIDTH-1:0] val);
        exp_t e;
        int old[NREGS];
        int old_wrap;
        int busv;
        @(negedge clk);
        reset         = rst;
        bus.load      = ld;
        bus.load_sel  = SEL_W'(lsel);
        bus.drive     = drv;
        bus.drive_sel = SEL_W'(dsel);
        bus.step      = stp;
        bus.step_dir  = dir;
        bus.save      = sv;
        bus.restore   = rs;
        tb_en         = !drv;
        tb_val        = val;

        old      = m_regs;
        old_wrap = m_wrap;
        busv     = drv ? ((dsel < NREGS) ? old[dsel] : 0) : int'(val);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = 0;
                m_sh[i]   = 0;
            end
            m_wrap    = 0;
            m_sh_wrap = 0;
        end else begin
            m_wrap = 0;
            if (stp && !(ld && lsel == XIDX)) begin
                if (!dir) begin
                    m_regs[XIDX] = (old[XIDX] + 1) % MOD;
                    m_wrap       = (old[XIDX] == MOD - 1) ? 1 : 0;
                end else begin
                    m_regs[XIDX] = (old[XIDX] + MOD - 1) % MOD;
                    m_wrap       = (old[XIDX] == 0) ? 1 : 0;
                end
            end
            if (ld && lsel < NREGS) m_regs[lsel] = busv;
`ifdef GPR_BANK_SHADOW_EN
            if (rs) begin
                m_regs = m_sh;
                m_wrap = m_sh_wrap;
            end
            if (sv) begin
                m_sh      = old;
                m_sh_wrap = old_wrap;
            end
`else
            if (sv || rs) unused_ctrl_cnt++;
`endif
        end

        for (int i = 0; i < NREGS; i++) e.regs[i*WIDTH +: WIDTH] = WIDTH'(m_regs[i]);
        e.wrap = (m_wrap != 0);
        e.dbus = drv ? ((dsel < NREGS) ? WIDTH'(m_regs[dsel]) : '0) : val;
        exp_q.push_back(e);
    endtask

    // Monitor: one output snapshot per rising edge, compared with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mon_cyc++;
                total++;
                if (bus.regs !== e.regs) begin
                    bad++;
                    $display("FAIL regs cyc=%0d got=%h want=%h", mon_cyc, bus.regs, e.regs);
                end
                total++;
                if (bus.wrap !== e.wrap) begin
                    bad++;
                    $display("FAIL wrap cyc=%0d got=%b want=%b", mon_cyc, bus.wrap, e.wrap);
                end
                total++;
                if (dbus !== e.dbus) begin
                    bad++;
                    $display("FAIL dbus cyc=%0d got=%h want=%h", mon_cyc, dbus, e.dbus);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0; bus.load_sel = '0; bus.drive = 1'b0; bus.drive_sel = '0;
        bus.step = 1'b0; bus.step_dir = 1'b0; bus.save = 1'b0; bus.restore = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 0;
            m_sh[i]   = 0;
        end

        cyc(H, L, 0, L, 0, L, L, L, L, 8'h00);
        cyc(L, H, 0, L, 0, L, L, L, L, 8'hAB);
        cyc(L, H, 3, L, 0, H, L, L, L, 8'hCD);
        cyc(H, H, 1, H, 0, H, H, L, L, 8'h77);   // reset beats load and step
        cyc(L, L, 0, L, 0, L, L, L, L, 8'h3C);   // bank must not drive the bus
        cyc(L, H, 1, L, 0, L, L, L, L, 8'h5A);
        cyc(L, L, 0, H, 1, L, L, L, L, 8'h00);
        cyc(L, H, 2, L, 0, L, L, L, L, 8'hFF);
        cyc(L, L, 0, L, 0, H, L, L, L, 8'h00);   // increment wraps
        cyc(L, L, 0, L, 0, L, L, L, L, 8'h00);   // wrap clears
        cyc(L, H, 0, L, 0, H, H, L, L, 8'h33);   // decrement wraps with parallel load
        cyc(L, H, 2, L, 0, L, L, L, L, 8'h10);
        cyc(L, H, 2, L, 0, H, L, L, L, 8'h80);   // load beats step
        cyc(L, H, 3, H, 3, L, L, L, L, 8'h00);   // self-load
        cyc(L, H, 0, H, 1, L, L, L, L, 8'h00);   // register-to-register move
        for (int i = 0; i < NREGS; i++) cyc(L, H, i, L, 0, L, L, L, L, WIDTH'(i + 1));
        cyc(L, L, 0, L, 0, L, L, H, L, 8'h00);
        cyc(L, H, 0, L, 0, L, L, L, L, 8'hEE);
        cyc(L, L, 0, H, 0, L, L, L, H, 8'h00);
        cyc(L, H, 1, L, 0, H, H, H, H, 8'h99);   // save+restore swap

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, NREGS - 1)), $urandom_range(0, 2) == 0,
                int'($urandom_range(0, NREGS - 1)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, WIDTH'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
Parametrised general-purpose register bank for the nic8 datapath. Generalises the fixed A/B/X/Q set to NREGS registers of WIDTH bits. All registers are loaded from, and can drive, the shared tri-state data bus. One designated index register carries an increment/decrement counter with a wrap flag, so pointer stepping no longer costs an ALU cycle.

Parameters:
NREGS, 4, number of registers (2..16)
WIDTH, 8, register and bus width in bits
XIDX, 2, index of the register with inc/dec capability (0..NREGS-1)
SEL_W, $clog2(NREGS), select width (derived, never overridden)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  write dbus into register load_sel at next edge
load_sel  input  SEL_W  target register for load
drive  input  1  drive register drive_sel onto dbus (combinational)
drive_sel  input  SEL_W  source register for drive
step  input  1  step index register XIDX at next edge
step_dir  input  1  0 = increment, 1 = decrement
dbus  inout  WIDTH  shared data bus
regs  output  NREGS*WIDTH  flattened contents, register i at bits [i*WIDTH +: WIDTH]
wrap  output  1  registered; set when the last step wrapped
save  input  1  shadow snapshot (feature only; tie 0 otherwise)
restore  input  1  shadow restore (feature only; tie 0 otherwise)

Behaviour:
- Reset (reset=1 at rising edge): all registers = 0, wrap = 0, shadow = 0. Reset overrides load, step, save and restore in the same cycle.
- Load: load=1 at edge -> reg[load_sel] <= dbus. Latency 1 cycle. Other registers are held.
- load_sel >= NREGS: the write is ignored and no register changes.
- Drive: dbus = reg[drive_sel] while drive=1, else 'z. The path is combinational with no latency.
- drive_sel >= NREGS: dbus = 0 while drive=1.
- Read-during-write: with drive and load both active, dbus carries the old value and the register captures that old value. A self-load is therefore a no-op.
- Step: step=1 -> reg[XIDX] <= reg[XIDX] + 1 (step_dir=0) or - 1 (step_dir=1), modulo 2^WIDTH.
- wrap: registered every edge; wrap <= step & (inc from all-ones, or dec from zero). wrap is 0 on cycles without a step.
- Simultaneous load and step:
  - load_sel == XIDX: load wins, no step, wrap <= 0.
  - otherwise both take effect in the same cycle.
- No internal FSM beyond the registers, wrap flag and optional shadow. All outputs are glitch-free registered values, except dbus.

Optional Feature:
GPR_BANK_SHADOW_EN
- Defined: adds one shadow copy of all NREGS registers and wrap, used for interrupt context save.
  - save=1 -> shadow <= current registers and wrap, captured before any same-cycle load or step.
  - restore=1 -> registers and wrap <= shadow. restore overrides load and step that cycle.
  - save and restore together: registers <= old shadow and shadow <= old registers, i.e. a swap.
- Not defined: no shadow storage; save and restore are ignored.

Test Plan:
- Reset: pulse reset for 1 cycle after arbitrary loads -> all regs = 0x00, wrap = 0, dbus = z when drive=0.
- Load/drive round trip: dbus=0x5A, load=1, load_sel=1 for 1 cycle; then drive=1, drive_sel=1 -> regs[15:8] = 0x5A and dbus = 0x5A in the same cycle drive is asserted.
- Increment wrap:
  - reg[2] = 0xFF, step=1, step_dir=0 -> reg[2] = 0x00, wrap=1 next cycle.
  - A following idle cycle -> wrap = 0.
- Decrement with parallel load: reg[2] = 0x00, step dir=1, plus load reg0 with 0x33 in the same cycle -> reg[2] = 0xFF, wrap=1, reg0 = 0x33.
- Load vs step conflict: reg[2] = 0x10, step=1 with load=1, load_sel=2, dbus=0x80 -> reg[2] = 0x80, wrap=0.
- Shadow (GPR_BANK_SHADOW_EN defined):
  - save with regs {1,2,3,4}, then load reg0 = 0xEE -> reg0 = 0xEE.
  - restore -> regs back to {1,2,3,4}.
  - Without the macro, the same restore leaves reg0 = 0xEE.
